// File: rtl/imm_encode.sv
// imm_encode: inserts a 32-bit immediate into the RV32I instruction fields
// selected by immsrc (I/S/B/J/U).
//
// The unmodified template bits carry the opcode, register and funct fields.
// The block is a two-entry pipeline with valid/ready handshakes on both sides.
// Stage 1 holds the encoded word. Stage 2 is the output register.
// flush discards every in-flight entry at the next edge.
//
// Optional feature: define IMM_RANGE_CHECK_EN to also flag immediates that the
// selected format cannot represent. The encoding itself is unchanged; dropped
// bits are simply truncated. Without the macro, err reports only an invalid
// immsrc.
module imm_encode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      immsrc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] template,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] instr,
  output logic            err
);

  // Place the immediate bits of the selected format over the template.
  function automatic logic [31:0] f_place(input logic [2:0]  src,
                                          input logic [31:0] v,
                                          input logic [31:0] t);
    logic [31:0] w;
    w = t;
    case (src)
      3'b000: w[31:20] = v[11:0];
      3'b001: begin
        w[31:25] = v[11:5];
        w[11:7]  = v[4:0];
      end
      3'b010: begin
        w[31]    = v[12];
        w[30:25] = v[10:5];
        w[11:8]  = v[4:1];
        w[7]     = v[11];
      end
      3'b011: begin
        w[31]    = v[20];
        w[30:21] = v[10:1];
        w[20]    = v[11];
        w[19:12] = v[19:12];
      end
      3'b100: w[31:12] = v[31:12];
      default: w = t;
    endcase
    return w;
  endfunction

  // Only encodings 000..100 name a real format.
  function automatic logic f_src_bad(input logic [2:0] src);
    return (src > 3'b100);
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  // An immediate is representable when the bits above the field's sign bit
  // all equal that sign bit; branch and jump offsets must also be even.
  function automatic logic f_range_bad(input logic [2:0]  src,
                                       input logic [31:0] v);
    logic bad;
    case (src)
      3'b000, 3'b001: bad = (v[31:11] != {21{v[11]}});
      3'b010:         bad = (v[31:12] != {20{v[12]}}) || v[0];
      3'b011:         bad = (v[31:20] != {12{v[20]}}) || v[0];
      3'b100:         bad = (v[11:0] != 12'h000);
      default:        bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  logic [31:0] w_enc;
  logic        w_err;
  logic        w_s1_load;
  logic        w_s2_load;

  logic        r_s1_valid;
  logic [31:0] r_s1_instr;
  logic        r_s1_err;
  logic        r_s2_valid;
  logic [31:0] r_s2_instr;
  logic        r_s2_err;

  // Encode the incoming transaction and work out its error flag.
  always_comb begin
    w_enc = f_place(immsrc, imm, template);
    w_err = f_src_bad(immsrc);
`ifdef IMM_RANGE_CHECK_EN
    if (!w_err) begin
      w_err = f_range_bad(immsrc, imm);
    end else begin
      w_err = 1'b1;
    end
`endif
  end

  // Stage load enables; in_ready follows out_ready combinationally so that a
  // full pipe can accept and emit in the same cycle.
  always_comb begin
    w_s2_load = !r_s2_valid || out_ready;
    w_s1_load = !r_s1_valid || w_s2_load;
    if (flush) begin
      in_ready = 1'b0;
    end else begin
      in_ready = w_s1_load;
    end
  end

  // Pipeline registers: flush clears both valids; data registers only move
  // when a valid entry is loaded, so the output holds steady under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_instr <= 32'h0000_0000;
      r_s1_err   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_instr <= 32'h0000_0000;
      r_s2_err   <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_instr <= r_s1_instr;
          r_s2_err   <= r_s1_err;
        end else begin
          r_s2_instr <= r_s2_instr;
          r_s2_err   <= r_s2_err;
        end
      end else begin
        r_s2_valid <= r_s2_valid;
      end
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_instr <= w_enc;
          r_s1_err   <= w_err;
        end else begin
          r_s1_instr <= r_s1_instr;
          r_s1_err   <= r_s1_err;
        end
      end else begin
        r_s1_valid <= r_s1_valid;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign instr     = r_s2_instr;
  assign err       = r_s2_err;

endmodule

// File: tb/tb_imm_encode.sv
// Self-checking bench for imm_encode: directed format vectors, backpressure,
// flush and reset cases, then randomized traffic against a reference model.
// The model encodes with masks/shifts and judges range with signed arithmetic.
// Define IMM_RANGE_CHECK_EN for both RTL and bench to cover the range checks.
`timescale 1ns/1ps
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  immsrc = 3'b000;
  logic [31:0] imm = 32'h0;
  logic [31:0] template = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        err;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
  } exp_t;
  exp_t q[$];

  imm_encode #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .template(template),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encoding from the field tables, using masks and shifts.
  function automatic logic [31:0] ref_instr(input logic [2:0] s, input logic [31:0] v, input logic [31:0] t);
    case (s)
      3'd0: return (t & 32'h000F_FFFF) | ((v & 32'h0000_0FFF) << 20);
      3'd1: return (t & 32'h01FF_F07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
      3'd2: return (t & 32'h01FF_F07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
                   | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
      3'd3: return (t & 32'h0000_0FFF) | (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                   | (((v >> 11) & 32'h1) << 20) | (v & 32'h000F_F000);
      3'd4: return (t & 32'h0000_0FFF) | (v & 32'hFFFF_F000);
      default: return t;
    endcase
  endfunction

  // Reference error flag: invalid format, plus optional range judgement.
  function automatic logic ref_err(input logic [2:0] s, input logic [31:0] v);
    int sv;
    sv = $signed(v);
    if (s > 3'd4) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    case (s)
      3'd0, 3'd1: return !(sv >= -2048 && sv <= 2047);
      3'd2:       return !(sv >= -4096 && sv <= 4095 && (sv % 2) == 0);
      3'd3:       return !(sv >= -1048576 && sv <= 1048575 && (sv % 2) == 0);
      default:    return (v % 32'd4096) != 32'd0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: inputs are already driven; check at negedge, update model at posedge.
  task automatic cycle();
    logic exp_rdy, exp_ov, do_in, do_out;
    @(negedge clk);
    exp_rdy = !flush && (q.size() < 2 || out_ready);
    exp_ov  = (q.size() > 0) && (edge_cnt >= q[0].acc + 1);
    check_val("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check_val("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      check_val("instr", instr, q[0].instr);
      check_val("err", {31'd0, err}, {31'd0, q[0].err});
    end
    do_in  = in_valid && exp_rdy;
    do_out = exp_ov && out_ready;
    @(posedge clk);
    edge_cnt++;
    if (flush) begin
      q.delete();
    end else begin
      if (do_out) void'(q.pop_front());
      if (do_in) q.push_back('{ref_instr(immsrc, imm, template), ref_err(immsrc, imm), edge_cnt});
    end
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] v, input logic [31:0] t);
    immsrc = s; imm = v; template = t;
  endtask

  // Single transaction through an empty pipe with fixed expectations.
  task automatic directed(input string tag, input logic [2:0] s, input logic [31:0] v,
                          input logic [31:0] t, input logic [31:0] e_instr, input logic e_err);
    out_ready = 1'b1;
    drive(s, v, t);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check_val({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, "_instr"}, instr, e_instr);
    check_val({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    cycle();
  endtask

  initial begin
    // Reset state.
    #2;
    check_val("rst_ov", {31'd0, out_valid}, 32'd0);
    check_val("rst_instr", instr, 32'h0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_rdy", {31'd0, in_ready}, 32'd1);

    // Directed format vectors.
    directed("I", 3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    directed("S", 3'd1, 32'd8,         32'h0011_2023, 32'h0011_2423, 1'b0);
    directed("U", 3'd4, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);
    directed("B", 3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    directed("J", 3'd3, 32'd8,         32'h0000_006F, 32'h0080_006F, 1'b0);
    directed("BAD", 3'd7, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
    directed("RI", 3'd0, 32'd2048, 32'h0000_0093, 32'h8000_0093, 1'b1);
    directed("RB6", 3'd2, 32'd6, 32'h0000_0063, 32'h0000_0363, 1'b0);
    directed("RB5", 3'd2, 32'd5, 32'h0000_0063, 32'h0000_0263, 1'b1);
`endif

    // Backpressure: three back-to-back inputs, only two fit.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(3'd0, 32'd1, 32'h0000_0013); cycle();
    drive(3'd0, 32'd2, 32'h0000_0013); cycle();
    drive(3'd0, 32'd3, 32'h0000_0013);
    #1;
    check_val("bp_rdy", {31'd0, in_ready}, 32'd0);
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    check_val("bp_hold", instr, 32'h0010_0013);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check_val("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with two entries in flight and an input presented.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(3'd1, 32'd4, 32'h0000_2023); cycle();
    drive(3'd1, 32'd12, 32'h0000_2023); cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check_val("fl_ov", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    cycle(); cycle();
    check_val("fl_stale", {31'd0, out_valid}, 32'd0);

    // Reset asserted mid-stream.
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(3'd4, 32'hABCD_E000, 32'h0000_0037); cycle(); cycle();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("mr_ov", {31'd0, out_valid}, 32'd0);
    check_val("mr_instr", instr, 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    edge_cnt++;
    #1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: v = $urandom & 32'hFFFF_F000;
        default: v = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      drive(3'($urandom_range(0, 7)), v, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_val("drain", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Inverse of the immediate extender: takes a 32-bit immediate value, a format select and a 32-bit instruction template, and inserts the immediate bits into the correct RV32I instruction positions.
- Used by the debug/self-test instruction injector to synthesise instructions fed to fetch.
- Two-stage registered pipeline with valid/ready handshake on both sides and a synchronous flush.

Parameters:
- XLEN, 32, data width of immediate and instruction; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous pipeline clear; drops all in-flight entries.
- in_valid  input  1  input transaction present.
- in_ready  output  1  pipeline can accept the input this cycle.
- immsrc  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U; 101-111 invalid.
- imm  input  32  immediate value, already in byte-offset form (B/J not pre-shifted).
- template  input  32  instruction with opcode/rd/rs/funct fields set; immediate field bits are ignored.
- out_valid  output  1  encoded instruction available.
- out_ready  input  1  consumer accepts the output this cycle.
- instr  output  32  encoded instruction.
- err  output  1  immediate not representable in the selected format, or invalid immsrc.

Behaviour:
- Reset (async, rst=1): both stage valids=0, out_valid=0, instr=0, err=0. in_ready=1 on the first cycle after release.
- Field placement in stage 1; non-immediate bits are copied from template:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
  - B: [31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11].
  - J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
  - Invalid immsrc: template is passed through unchanged and err=1.
- Stage 1 register holds encoded word plus err; stage 2 is the output register.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when it is empty or stage 2 loads.
  - in_ready = !s1_valid || s2_load (combinational from out_ready).
- Latency: 2 cycles. Input accepted at edge N appears on out_valid/instr after edge N+1. Throughput is 1 per cycle with out_ready held high.
- Capacity is 2 entries. With out_ready=0, in_ready drops after 2 accepted inputs.
- Output stability: instr and err are held stable while out_valid && !out_ready.
- flush=1: both valids cleared at the next edge, and any input presented that cycle is discarded. in_ready=0 during flush. flush has priority over all other events.
- Simultaneous accept and emit with the pipeline full and out_ready=1: both transfers occur and occupancy is unchanged.
- rst asserted mid-stream: all entries are lost immediately; no partial output is ever presented.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- When defined, err is also set when:
  - I/S: imm is not the sign-extension of imm[11:0].
  - B: imm is not the sign-extension of imm[12:0], or imm[0]=1.
  - J: imm is not the sign-extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0] != 0.
- Dropped bits are silently truncated in all cases; encoding is otherwise identical.
- When not defined, err reports only invalid immsrc.

Test Plan:
- I: immsrc=000, template=0x00000093, imm=0xFFFFFFFF -> instr=0xFFF00093, err=0, out_valid 2 cycles after accept.
- S and U: immsrc=001, template=0x00112023, imm=8 -> 0x00112423. Then immsrc=100, template=0x000002B7, imm=0x12345000 -> 0x123452B7.
- B and J: immsrc=010, template=0x00000063, imm=0xFFFFFFFC -> 0xFE000EE3. Then immsrc=011, template=0x0000006F, imm=8 -> 0x0080006F.
- Error:
  - With IMM_RANGE_CHECK_EN: I with imm=2048 -> err=1; B with imm=6 -> err=0; B with imm=5 -> err=1.
  - With or without the macro: immsrc=111 -> instr=template, err=1.
- Backpressure: out_ready=0, drive 3 back-to-back inputs -> only 2 accepted, in_ready=0 on the third. Raise out_ready -> outputs appear in order, instr stable while stalled.
- Flush/reset: 2 entries in flight, pulse flush -> out_valid=0 next cycle, no stale output. Assert rst mid-stream -> out_valid=0 and instr=0 immediately.
